// File: rtl/fifo_flow_if.sv
// Handshake, threshold and status bundle between a fifo_flow instance and its
// upstream/downstream logic. The slave side is the FIFO itself.
interface fifo_flow_if #(
    parameter int DATA_SIZE = 10,
    parameter int ADDR_SIZE = 3
);
    logic                 write;
    logic [DATA_SIZE-1:0] data_in;
    logic                 read;
    logic [ADDR_SIZE:0]   th_almost_full;
    logic [ADDR_SIZE:0]   th_almost_empty;
    logic                 err_clear;
    logic [DATA_SIZE-1:0] data_out;
    logic                 valid_out;
    logic [ADDR_SIZE:0]   count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 almost_empty;
    logic                 almost_full;
    logic                 fifo_pause;
    logic                 overflow_err;
    logic                 underflow_err;

    modport master (
        output write, data_in, read, th_almost_full, th_almost_empty, err_clear,
        input  data_out, valid_out, count, fifo_empty, fifo_full, almost_empty,
               almost_full, fifo_pause, overflow_err, underflow_err
    );

    modport slave (
        input  write, data_in, read, th_almost_full, th_almost_empty, err_clear,
        output data_out, valid_out, count, fifo_empty, fifo_full, almost_empty,
               almost_full, fifo_pause, overflow_err, underflow_err
    );
endinterface

// File: rtl/fifo_flow.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, hysteretic pause output, registered read data with valid strobe,
// and sticky software-clearable overflow/underflow flags.
module fifo_flow #(
    parameter int DATA_SIZE = 10,
    parameter int ADDR_SIZE = 3
) (
    input  logic        clk,
    input  logic        reset,
    fifo_flow_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] FULL_CNT = {1'b1, {ADDR_SIZE{1'b0}}};

    typedef enum logic {
        FLOW,
        PAUSED
    } pause_state_t;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr;
    logic [ADDR_SIZE-1:0] rd_ptr;
    logic [ADDR_SIZE:0]   count_q;
    logic [DATA_SIZE-1:0] data_q;
    logic                 valid_q;
    logic                 ovf_q;
    logic                 unf_q;
    logic                 empty;
    logic                 full;
    logic                 rd_acc;
    logic                 wr_acc;
    logic                 ovf_set;
    logic                 unf_set;
    pause_state_t         pause_q;
    pause_state_t         pause_d;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign rd_acc  = bus.read && !empty;
    assign wr_acc  = bus.write && (!full || rd_acc);
    assign ovf_set = bus.write && full && !rd_acc;
    assign unf_set = bus.read && empty;

    // Storage array; no reset needed since contents are only read when occupied.
    // On a full read+write wr_ptr equals rd_ptr, and the pop below samples the
    // old word before this write lands.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointers, occupancy, registered read data and sticky error flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            valid_q <= rd_acc;
            if (rd_acc) begin
                data_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            ovf_q <= ovf_set || (ovf_q && !bus.err_clear);
            unf_q <= unf_set || (unf_q && !bus.err_clear);
        end
    end

    // Pause state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pause_q <= FLOW;
        end else begin
            pause_q <= pause_d;
        end
    end

    // Pause hysteresis: assert at the almost-full threshold, release at almost-empty.
    always_comb begin
        pause_d = pause_q;
        case (pause_q)
            FLOW:    if (count_q >= bus.th_almost_full)  pause_d = PAUSED;
            PAUSED:  if (count_q <= bus.th_almost_empty) pause_d = FLOW;
            default: pause_d = FLOW;
        endcase
    end

    assign bus.data_out      = data_q;
    assign bus.valid_out     = valid_q;
    assign bus.count         = count_q;
    assign bus.fifo_empty    = empty;
    assign bus.fifo_full     = full;
    assign bus.almost_full   = (count_q >= bus.th_almost_full);
    assign bus.almost_empty  = (count_q <= bus.th_almost_empty) && !empty;
    assign bus.fifo_pause    = (pause_q == PAUSED);
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;
endmodule

// File: tb/tb_fifo_flow.sv
// Scoreboard bench for fifo_flow: a queue-based reference model predicts status
// every cycle and pushes expected pop data; a monitor checks each valid_out.
module tb_fifo_flow;
    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fifo_flow_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus ();

    fifo_flow #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q   [$];
    bit m_pause, m_ovf, m_unf;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int n;
        int taf;
        int tae;
        n   = model_q.size();
        taf = int'(bus.th_almost_full);
        tae = int'(bus.th_almost_empty);
        chk("count",         32'(bus.count), 32'(n));
        chk("fifo_empty",    32'(bus.fifo_empty), 32'(n == 0));
        chk("fifo_full",     32'(bus.fifo_full), 32'(n == DEPTH));
        chk("almost_full",   32'(bus.almost_full), 32'(n >= taf));
        chk("almost_empty",  32'(bus.almost_empty), 32'((n <= tae) && (n != 0)));
        chk("fifo_pause",    32'(bus.fifo_pause), 32'(m_pause));
        chk("overflow_err",  32'(bus.overflow_err), 32'(m_ovf));
        chk("underflow_err", 32'(bus.underflow_err), 32'(m_unf));
    endtask

    // One clock cycle of stimulus; the model advances with the same inputs.
    task automatic step(bit w, logic [DW-1:0] d, bit r, bit clr, bit rst_n);
        int  n;
        bit  racc, wacc, np, nov, nun;
        n = model_q.size();
        bus.write     = w;
        bus.data_in   = d;
        bus.read      = r;
        bus.err_clear = clr;
        reset         = rst_n;
        racc = r && (n > 0);
        wacc = w && ((n < DEPTH) || racc);
        if (!m_pause) np = (n >= int'(bus.th_almost_full));
        else          np = !(n <= int'(bus.th_almost_empty));
        nov = (w && n == DEPTH && !racc) || (m_ovf && !clr);
        nun = (r && n == 0) || (m_unf && !clr);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_q.delete();
            m_pause = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            if (racc) exp_q.push_back(model_q.pop_front());
            if (wacc) model_q.push_back(d);
            m_pause = np;
            m_ovf   = nov;
            m_unf   = nun;
        end
        check_status();
    endtask

    // Monitor: every valid_out must match the next expected word; otherwise data_out holds.
    initial begin
        logic [DW-1:0] hold;
        logic [DW-1:0] e;
        bit rst_edge;
        hold = '0;
        forever begin
            @(posedge clk);
            rst_edge = (reset == 1'b0);
            @(negedge clk);
            if (rst_edge) hold = '0;
            if (bus.valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("valid_out_unexpected", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", 32'(bus.data_out), 32'(e));
                    hold = e;
                end
            end else begin
                chk("data_out_hold", 32'(bus.data_out), 32'(hold));
            end
        end
    end

    initial begin
        bus.write = 1'b0;
        bus.data_in = '0;
        bus.read = 1'b0;
        bus.err_clear = 1'b0;
        bus.th_almost_full  = 4'd6;
        bus.th_almost_empty = 4'd3;

        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 0);

        // Fill and drain
        for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 1);
        step(0, '0, 0, 0, 1);

        // Wrap-around
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) step(1, DW'($urandom), 0, 0, 1);
            for (int i = 0; i < 6; i++) step(0, '0, 1, 0, 1);
        end

        // Pause hysteresis with thresholds 6/3
        for (int i = 0; i < 6; i++) step(1, DW'($urandom), 0, 0, 1);
        step(0, '0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1, 0, 1);
            step(0, '0, 0, 0, 1);
        end

        // Full with simultaneous read+write, then overflow and clear
        while (model_q.size() < DEPTH) step(1, DW'($urandom), 0, 0, 1);
        step(1, DW'($urandom), 1, 0, 1);
        step(1, DW'($urandom), 0, 0, 1);
        step(0, '0, 0, 1, 1);
        step(0, '0, 0, 0, 1);

        // Empty boundary: read+write on empty, then clear racing an empty read
        while (model_q.size() > 0) step(0, '0, 1, 0, 1);
        step(1, DW'($urandom), 1, 0, 1);
        step(0, '0, 1, 0, 1);
        step(0, '0, 1, 1, 1);
        step(0, '0, 0, 1, 1);

        // Reset mid-operation with pause asserted at count 5
        for (int i = 0; i < 6; i++) step(1, DW'($urandom), 0, 0, 1);
        step(0, '0, 1, 0, 1);
        step(0, '0, 0, 0, 1);
        chk("pause_before_reset", 32'(bus.fifo_pause), 32'(1));
        step(1, DW'($urandom), 1, 1, 0);
        step(0, '0, 1, 0, 1);
        step(0, '0, 0, 1, 1);

        // Randomized traffic with shifting bias, thresholds, clears and rare resets
        for (int c = 0; c < 3000; c++) begin
            int wb;
            if (c % 150 == 0) begin
                bus.th_almost_full  = 4'($urandom_range(0, 15));
                bus.th_almost_empty = 4'($urandom_range(0, 15));
            end
            wb = ((c / 100) % 2 == 0) ? 70 : 30;
            step(($urandom_range(0, 99) < wb), DW'($urandom),
                 ($urandom_range(0, 99) < (100 - wb)),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 299) != 0));
        end

        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
